mips_branch_ctrl: RTL

//  ID-stage branch controller for the pipelined MIPS core. Sequences the BEQ/BNE equality comparator.
//  - Selects comparator operand forwarding.
//  - Detects data hazards on branch operands and stalls IF/ID until operands are valid.
//  - Resolves the branch and drives PC select plus IF/ID flush.
//  - Keeps saturating branch/stall performance counters.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mips_sat_counter.sv | 29 ++
 rtl/mips_branch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the ID-stage branch controller.
//  - REG_AW       register index width
//  - OP_BEQ/BNE   primary opcodes of the two branches handled in ID
//  - br_state_e   branch controller FSM state (IDLE=0, WAIT=1)
//  - stall_need   stall cycles needed by one branch operand
package mips_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  // A producer in EX wins over one in MEM because it is the younger write.
  // A non-load in MEM is not a stall: its ALU result is forwarded instead.
  function automatic logic [1:0] stall_need(input logic ex_match,
                                            input logic ex_load,
                                            input logic mem_match,
                                            input logic mem_load);
    if (ex_match) return ex_load ? 2'd2 : 2'd1;
    if (mem_match && mem_load) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter: saturating up-counter for performance statistics.
//  clk    in   core clock
//  reset  in   synchronous, active-high clear
//  inc    in   count one event this cycle
//  count  out  CNT_W-bit registered count, holds at all-ones
module mips_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mips_branch_ctrl.sv
// mips_branch_ctrl: ID-stage BEQ/BNE controller.
//  Inputs : clk, reset (sync, active-high), id_beq/id_bne, id_rs/id_rt,
//           EX and MEM stage regwrite/memread/rd, cmp_equal.
//  Outputs: fwd_a/fwd_b comparator forwarding selects, stall, idex_bubble,
//           pc_src, flush_ifid, and saturating br/taken/stall counters.
module mips_branch_ctrl #(
  parameter int unsigned REG_AW = mips_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_beq,
  input  logic              id_bne,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              cmp_equal,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              stall,
  output logic              idex_bubble,
  output logic              pc_src,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  stall_count
);

  import mips_pkg::*;

  br_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic       br;
  logic       ex_a, ex_b, mem_a, mem_b;
  logic [1:0] need_a, need_b, need;
  logic       taken;
  logic       br_inc, taken_inc;

  // Hazard detection; register 0 is hard-wired and never a dependency.
  assign br    = id_beq | id_bne;
  assign ex_a  = ex_regwrite  && (ex_rd  == id_rs) && (id_rs != '0);
  assign ex_b  = ex_regwrite  && (ex_rd  == id_rt) && (id_rt != '0);
  assign mem_a = mem_regwrite && (mem_rd == id_rs) && (id_rs != '0);
  assign mem_b = mem_regwrite && (mem_rd == id_rt) && (id_rt != '0);

  assign need_a = stall_need(ex_a, ex_memread, mem_a, mem_memread);
  assign need_b = stall_need(ex_b, ex_memread, mem_b, mem_memread);
  assign need   = (need_a > need_b) ? need_a : need_b;
  assign taken  = cmp_equal ^ id_bne;

  // Forwarding selects track the live inputs in every state.
  assign fwd_a = !reset && mem_a && !mem_memread;
  assign fwd_b = !reset && mem_b && !mem_memread;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A one-cycle hazard stalls in IDLE and re-evaluates next cycle.
        if (br && (need == 2'd2)) begin
          state_d = ST_WAIT;
          cnt_d   = 2'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = 1'b0;
    flush_ifid  = 1'b0;
    br_inc      = 1'b0;
    taken_inc   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (br) begin
            if (need == 2'd0) begin
              pc_src     = taken;
              flush_ifid = taken;
              br_inc     = 1'b1;
              taken_inc  = taken;
            end else begin
              stall       = 1'b1;
              idex_bubble = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          stall       = 1'b1;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  mips_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .reset(reset), .inc(br_inc), .count(br_count)
  );

  mips_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk(clk), .reset(reset), .inc(taken_inc), .count(taken_count)
  );

  mips_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .count(stall_count)
  );

endmodule
